// File: rtl/trap_injector_if.sv
// Bus-side signal bundle for the trap injector: Z80 strobes and request in,
// data drive, inhibit and status out.
interface trap_injector_if;
  logic       m1_n;
  logic       mreq_n;
  logic       rd_n;
  logic       new_isr;
  logic       trap_req;
  logic [7:0] data_out;
  logic       data_oe;
  logic       mem_inhibit;
  logic       trap_ack;
  logic       trap_abort;
  logic       busy;

  modport master (
    output m1_n, mreq_n, rd_n, new_isr, trap_req,
    input  data_out, data_oe, mem_inhibit, trap_ack, trap_abort, busy
  );

  modport slave (
    input  m1_n, mreq_n, rd_n, new_isr, trap_req,
    output data_out, data_oe, mem_inhibit, trap_ack, trap_abort, busy
  );
endinterface

// File: rtl/trap_injector.sv
// Forces a CALL to the trap handler by substituting the opcode and address
// bytes on the Z80 data bus at the next instruction-boundary fetch.
module trap_injector #(
  parameter logic [7:0]  CALL_OPCODE = 8'hCD,
  parameter logic [15:0] TRAP_VECTOR = 16'hFF00
) (
  input  logic           clk,
  input  logic           reset,
  trap_injector_if.slave bus
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ARMED   = 4'd1;
  localparam logic [3:0] OP      = 4'd2;
  localparam logic [3:0] WAIT_LO = 4'd3;
  localparam logic [3:0] LO      = 4'd4;
  localparam logic [3:0] WAIT_HI = 4'd5;
  localparam logic [3:0] HI      = 4'd6;
  localparam logic [3:0] DONE    = 4'd7;
  localparam logic [3:0] ABORT   = 4'd8;

  logic [3:0] state, state_nx;
  logic [1:0] m1_sy, mreq_sy, rd_sy;
  logic       rd_active, rd_active_q;
  logic       read_start, read_end, fetch, operand;
  logic [7:0] drive_byte;

  // Strobes are asynchronous to clk; idle level is 1 so reset loads 1s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1_sy       <= '1;
      mreq_sy     <= '1;
      rd_sy       <= '1;
      rd_active_q <= 1'b0;
    end else begin
      m1_sy       <= {m1_sy[0], bus.m1_n};
      mreq_sy     <= {mreq_sy[0], bus.mreq_n};
      rd_sy       <= {rd_sy[0], bus.rd_n};
      rd_active_q <= rd_active;
    end
  end

  assign rd_active  = ~mreq_sy[1] & ~rd_sy[1];
  assign read_start = rd_active & ~rd_active_q;
  assign read_end   = rd_sy[1];
  assign fetch      = read_start & ~m1_sy[1];
  assign operand    = read_start & m1_sy[1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.trap_req) state_nx = ARMED;
      ARMED: begin
        if (fetch && bus.new_isr) state_nx = OP;
        else if (!bus.trap_req)   state_nx = IDLE;
      end
      OP:      if (read_end) state_nx = WAIT_LO;
      WAIT_LO: begin
        if (fetch)        state_nx = ABORT;
        else if (operand) state_nx = LO;
      end
      LO:      if (read_end) state_nx = WAIT_HI;
      WAIT_HI: begin
        if (fetch)        state_nx = ABORT;
        else if (operand) state_nx = HI;
      end
      HI:      if (read_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    drive_byte = '0;
    case (state_nx)
      OP:      drive_byte = CALL_OPCODE;
      LO:      drive_byte = TRAP_VECTOR[7:0];
      HI:      drive_byte = TRAP_VECTOR[15:8];
      default: drive_byte = '0;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state and never glitch on multi-bit state transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.data_out    <= '0;
      bus.data_oe     <= 1'b0;
      bus.mem_inhibit <= 1'b0;
      bus.trap_ack    <= 1'b0;
      bus.trap_abort  <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.data_out    <= drive_byte;
      bus.data_oe     <= (state_nx == OP) || (state_nx == LO) || (state_nx == HI);
      bus.mem_inhibit <= (state_nx == OP) || (state_nx == LO) || (state_nx == HI);
      bus.trap_ack    <= (state_nx == DONE);
      bus.trap_abort  <= (state_nx == ABORT);
      bus.busy        <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_trap_injector.sv
// Self-checking bench for trap_injector: table-driven bus cycles with a
// scoreboard of expected injected bytes, plus hand-written corner sequences.
module tb_trap_injector;

  localparam int K_FETCH = 0;
  localparam int K_OPER  = 1;
  localparam int K_REFR  = 2;
  localparam int K_IACK  = 3;
  localparam int K_WRITE = 4;

  typedef struct {
    int         kind;
    bit         nisr;
    bit         treq;
    bit         drive;
    logic [7:0] exp_byte;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  trap_injector_if bif ();

  trap_injector #(.CALL_OPCODE(8'hCD), .TRAP_VECTOR(16'hFF00)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         ack_cnt = 0;
  int         abort_cnt = 0;
  int         ack_idx = 0;
  logic [7:0] exp_q[$];
  bit         busy_hist[$];
  logic       oe_q = 1'b0;
  logic [7:0] cur_exp = '0;
  vec_t       vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each new drive and tracks pulses.
  always @(negedge clk) begin
    busy_hist.push_back(bif.busy);
    check("inhibit_eq_oe", bif.mem_inhibit, bif.data_oe);
    if (bif.trap_ack) begin
      ack_cnt++;
      ack_idx = busy_hist.size() - 1;
    end
    if (bif.trap_abort) abort_cnt++;
    if (bif.data_oe && !oe_q) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_drive: got %0h expected no drive at %0t", bif.data_out, $time);
      end else begin
        cur_exp = exp_q.pop_front();
        check("drive_byte", bif.data_out, cur_exp);
      end
    end else if (bif.data_oe) begin
      check("drive_stable", bif.data_out, cur_exp);
    end
    oe_q = bif.data_oe;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic bus_idle();
    bif.m1_n = 1'b1; bif.mreq_n = 1'b1; bif.rd_n = 1'b1;
  endtask

  task automatic bus_cycle(input vec_t v, input string nm);
    bit seen;
    seen = 1'b0;
    bif.new_isr  = v.nisr;
    bif.trap_req = v.treq;
    if (v.drive) exp_q.push_back(v.exp_byte);
    case (v.kind)
      K_FETCH: begin bif.m1_n = 1'b0; bif.mreq_n = 1'b0; bif.rd_n = 1'b0; end
      K_OPER:  begin bif.m1_n = 1'b1; bif.mreq_n = 1'b0; bif.rd_n = 1'b0; end
      K_REFR:  begin bif.m1_n = 1'b1; bif.mreq_n = 1'b0; bif.rd_n = 1'b1; end
      K_IACK:  begin bif.m1_n = 1'b0; bif.mreq_n = 1'b1; bif.rd_n = 1'b0; end
      default: begin bif.m1_n = 1'b1; bif.mreq_n = 1'b0; bif.rd_n = 1'b1; end
    endcase
    repeat (6) begin @(negedge clk); seen |= bif.data_oe; end
    bus_idle();
    repeat (6) begin @(negedge clk); seen |= bif.data_oe; end
    check({nm, "_drove"}, seen, v.drive);
    check({nm, "_released"}, bif.data_oe, 1'b0);
  endtask

  initial begin
    int a0, b0;
    // prefix wait, basic inject, refresh/IACK/write immunity
    vecs[0]  = '{K_FETCH, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{K_FETCH, 1'b1, 1'b1, 1'b1, 8'hCD};
    vecs[2]  = '{K_REFR,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{K_IACK,  1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{K_WRITE, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{K_OPER,  1'b0, 1'b1, 1'b1, 8'h00};
    vecs[6]  = '{K_WRITE, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{K_OPER,  1'b0, 1'b1, 1'b1, 8'hFF};
    // abort in WAIT_HI
    vecs[8]  = '{K_FETCH, 1'b1, 1'b1, 1'b1, 8'hCD};
    vecs[9]  = '{K_OPER,  1'b0, 1'b0, 1'b1, 8'h00};
    vecs[10] = '{K_FETCH, 1'b1, 1'b0, 1'b0, 8'h00};
    // fresh inject
    vecs[11] = '{K_FETCH, 1'b1, 1'b1, 1'b1, 8'hCD};
    vecs[12] = '{K_OPER,  1'b0, 1'b0, 1'b1, 8'h00};
    vecs[13] = '{K_OPER,  1'b0, 1'b0, 1'b1, 8'hFF};

    bus_idle();
    bif.new_isr = 1'b0; bif.trap_req = 1'b0;
    #2;
    check("rst_data_out", bif.data_out, 8'h00);
    check("rst_data_oe", bif.data_oe, 1'b0);
    check("rst_inhibit", bif.mem_inhibit, 1'b0);
    check("rst_ack", bif.trap_ack, 1'b0);
    check("rst_abort", bif.trap_abort, 1'b0);
    check("rst_busy", bif.busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) bus_cycle(vecs[i], $sformatf("v%0d", i));
    check("basic_ack_cnt", ack_cnt, 1);
    check("basic_abort_cnt", abort_cnt, 0);
    check("busy_at_ack", busy_hist[ack_idx], 1'b1);
    check("busy_after_ack", busy_hist[ack_idx + 1], 1'b0);
    check("rearm_after_ack", busy_hist[ack_idx + 2], 1'b1);
    bif.trap_req = 1'b0;
    repeat (3) @(negedge clk);
    check("basic_idle", bif.busy, 1'b0);

    for (int i = 8; i < 11; i++) bus_cycle(vecs[i], $sformatf("v%0d", i));
    check("abort_cnt", abort_cnt, 1);
    check("abort_no_ack", ack_cnt, 1);
    check("abort_idle", bif.busy, 1'b0);

    // reset while the low vector byte is on the bus
    bus_cycle(vecs[11], "rst_fetch");
    bif.trap_req = 1'b0;
    exp_q.push_back(8'h00);
    bif.m1_n = 1'b1; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    repeat (5) @(negedge clk);
    check("lo_drive_on", bif.data_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_oe", bif.data_oe, 1'b0);
    check("async_inhibit", bif.mem_inhibit, 1'b0);
    check("async_busy", bif.busy, 1'b0);
    bus_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_ack", ack_cnt, 1);
    check("rst_no_abort", abort_cnt, 1);
    for (int i = 11; i < 14; i++) bus_cycle(vecs[i], $sformatf("v%0d", i));
    check("fresh_ack_cnt", ack_cnt, 2);

    // drive latency: 3 clks from strobe edge to output change
    bif.trap_req = 1'b1; bif.new_isr = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'hCD);
    @(posedge clk); #1;
    bif.m1_n = 1'b0; bif.mreq_n = 1'b0; bif.rd_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lat_rise_early", bif.data_oe, 1'b0);
    @(negedge clk);
    check("lat_rise", bif.data_oe, 1'b1);
    bif.trap_req = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lat_fall_early", bif.data_oe, 1'b1);
    @(negedge clk);
    check("lat_fall", bif.data_oe, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 12; i < 14; i++) bus_cycle(vecs[i], $sformatf("lat_v%0d", i));
    check("lat_ack_cnt", ack_cnt, 3);

    // withdrawn request
    a0 = ack_cnt; b0 = abort_cnt;
    bif.trap_req = 1'b1;
    repeat (5) @(negedge clk);
    check("withdraw_armed", bif.busy, 1'b1);
    bif.trap_req = 1'b0;
    repeat (4) @(negedge clk);
    check("withdraw_idle", bif.busy, 1'b0);
    check("withdraw_no_ack", ack_cnt, a0);
    check("withdraw_no_abort", abort_cnt, b0);
    check("withdraw_no_oe", bif.data_oe, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_injector.md
Name: trap_injector

Overview:
- Drives opcode bytes onto the Z80 data bus to force a CALL to the trap handler.
- It is the supply side of the opcode path; the opcode tracker is the observe side.
- On a trap request, it waits for an instruction-boundary opcode fetch (new_isr = 1), then substitutes CALL nn with the handler vector over three consecutive memory reads.
- Sits in the CPLD between the CPU bus and the memory-inhibit logic, and is clocked by the CPLD clock (at least 4x CPU clock).

Parameters:
- CALL_OPCODE, 8'hCD, opcode byte driven during the hijacked M1 fetch.
- TRAP_VECTOR, 16'hFF00, handler address; low byte is driven first.

Ports:
- clk  input  1  CPLD system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m1_n  input  1  Z80 M1, async to clk.
- mreq_n  input  1  Z80 MREQ, async to clk.
- rd_n  input  1  Z80 RD, async to clk.
- new_isr  input  1  from opcode tracker; 1 means the next M1 begins a new instruction.
- trap_req  input  1  level request to inject a trap call.
- data_out  output  8  byte to drive on the CPU data bus.
- data_oe  output  1  data bus output enable.
- mem_inhibit  output  1  suppresses RAM/ROM response while injecting.
- trap_ack  output  1  one-clk pulse when the CALL sequence completes.
- trap_abort  output  1  one-clk pulse when the sequence is abandoned.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchronisation:
  - m1_n, mreq_n and rd_n pass through 2-flop synchronisers; all decisions use the synced values.
  - Read start = synced (mreq_n = 0, rd_n = 0) this clk and not true the previous clk.
  - Read end = synced rd_n = 1.
  - Fetch = read start with synced m1_n = 0.
  - Operand read = read start with synced m1_n = 1.
- Reset: asynchronous, returns to IDLE. All outputs reset to 0: data_oe, mem_inhibit, trap_ack, trap_abort, busy, data_out = 8'h00. Synchroniser flops reset to 1 (bus idle).
- States:
  - IDLE: trap_req = 1 -> ARMED.
  - ARMED: fetch with new_isr = 1 -> OP. A fetch with new_isr = 0 (prefix continuation) is ignored. If trap_req drops before a qualifying fetch -> IDLE, no ack, no abort.
  - OP: data_out = CALL_OPCODE, data_oe = mem_inhibit = 1 from the clk after the fetch start until read end; then -> WAIT_LO.
  - WAIT_LO: operand read -> LO. Any fetch -> ABORT.
  - LO: drive TRAP_VECTOR[7:0] until read end -> WAIT_HI.
  - WAIT_HI: operand read -> HI. Any fetch -> ABORT.
  - HI: drive TRAP_VECTOR[15:8] until read end -> DONE.
  - DONE: trap_ack = 1 for one clk -> IDLE.
  - ABORT: trap_abort = 1 for one clk, drivers released -> IDLE.
- Drive latency: data_oe and mem_inhibit rise 3 clks after the bus read strobe falls (2 sync + 1 register) and fall 3 clks after rd_n rises. data_out is stable the whole time data_oe = 1.
- Ignored cycles:
  - Refresh cycles (mreq_n low, rd_n high) never count as reads.
  - Interrupt acknowledge M1 (mreq_n high) never counts as a fetch.
  - Write cycles in WAIT states (stack pushes) are ignored.
- Request handling: trap_req is not re-sampled from OP onward. A request held high through DONE re-arms only after IDLE is re-entered (earliest ARMED is 2 clks after trap_ack).
- Return address: the CPU pushes fetch PC+3; the handler subtracts 3 before resuming. This is a firmware contract, not enforced here.
- Reset mid-sequence: drivers are released immediately (asynchronously); no ack or abort pulse.

Test Plan:
- Basic inject: trap_req = 1, then fetch with new_isr = 1 and two operand reads -> bus sees CD, 00, FF in order; trap_ack pulses once; busy falls the clk after the ack.
- Prefix wait: trap_req = 1, fetch with new_isr = 0 (byte after ED), then fetch with new_isr = 1 -> the first fetch is untouched (data_oe = 0); injection occurs on the second.
- Refresh/IACK immunity: in WAIT_LO, apply a refresh cycle and an M1+IORQ acknowledge -> no state advance, data_oe = 0; a following operand read gets 8'h00.
- Abort: in WAIT_HI, a fetch arrives -> trap_abort pulses, data_oe = 0, state IDLE, no trap_ack.
- Reset mid-drive: assert reset during LO with data_oe = 1 -> data_oe, mem_inhibit and busy go 0 asynchronously; after release, a fresh request injects normally.
- Withdrawn request: trap_req pulses for 5 clks with no fetch -> returns to IDLE; no outputs asserted.
